// File: rtl/time_sync_ctrl_if.sv
// Decoder/counter-chain side bus of time_sync_ctrl.
// master drives frames and markers; slave (the sequencer) drives the counter controls.
interface time_sync_ctrl_if;
   logic        frame_valid_i;
   logic [31:0] frame_bcd_i;
   logic        minute_mark_i;
   logic        inc_o;
   logic        load_o;
   logic [31:0] load_bcd_o;
   logic        synced_o;
   logic        pending_o;
   logic        reject_o;

   modport master (
      output frame_valid_i, frame_bcd_i, minute_mark_i,
      input  inc_o, load_o, load_bcd_o, synced_o, pending_o, reject_o
   );

   modport slave (
      input  frame_valid_i, frame_bcd_i, minute_mark_i,
      output inc_o, load_o, load_bcd_o, synced_o, pending_o, reject_o
   );
endinterface

// File: rtl/time_sync_ctrl.sv
// Sequencer for the calendar counter chain: 1 Hz prescaler, MSF frame arm/load, sync/holdover tracking.
// Define FRAME_CHECK_EN to reject frames with implausible BCD date/time fields.
module time_sync_ctrl #(
   parameter int TICK_DIV        = 10000,
   parameter int ARMED_TIMEOUT_S = 62,
   parameter int HOLDOVER_S      = 3600
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   time_sync_ctrl_if.slave  bus
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int TW = $clog2(ARMED_TIMEOUT_S + 1);
   localparam int HW = $clog2(HOLDOVER_S + 1);
   localparam logic [PW-1:0] PreLast  = PW'(TICK_DIV - 1);
   localparam logic [TW-1:0] ToutLast = TW'(ARMED_TIMEOUT_S);
   localparam logic [HW-1:0] HoldLast = HW'(HOLDOVER_S);

   typedef enum logic [1:0] {
      UNSYNC,
      ARMED,
      SYNCED
   } state_e;

   state_e        state_q;
   logic [PW-1:0] preCnt_q;
   logic [TW-1:0] timeout_q;
   logic [TW-1:0] timeout_d;
   logic [HW-1:0] holdover_q;
   logic [HW-1:0] holdover_d;
   logic [31:0]   shadow_q;
   logic [31:0]   loadBcd_q;
   logic          inc_q;
   logic          load_q;
   logic          synced_q;
   logic          pending_q;

   logic          terminal;
   logic          loadNow;
   logic          incNow;
   logic          frameOk;
   logic          frameAccept;
   logic          toutExpire;
   logic          holdExpire;

   // A load restarts the second, so a coinciding terminal count must not also tick.
   assign terminal    = (preCnt_q == PreLast);
   assign loadNow     = (state_q == ARMED) && bus.minute_mark_i;
   assign incNow      = terminal && !loadNow;
   assign frameAccept = bus.frame_valid_i && frameOk;

   assign timeout_d   = timeout_q + 1'b1;
   assign holdover_d  = holdover_q + 1'b1;
   assign toutExpire  = (timeout_d == ToutLast);
   assign holdExpire  = synced_q && incNow && (holdover_d == HoldLast);

`ifdef FRAME_CHECK_EN
   logic reject_q;

   function automatic logic frameValid(input logic [31:0] f);
      int   month;
      int   day;
      int   hour;
      int   minute;
      logic digitsOk;
      digitsOk = (f[31:28] <= 4'd9) && (f[27:24] <= 4'd9) && (f[22:19] <= 4'd9) &&
                 (f[16:13] <= 4'd9) && (f[10:7]  <= 4'd9) && (f[3:0]   <= 4'd9);
      month  = 10 * int'(f[23])    + int'(f[22:19]);
      day    = 10 * int'(f[18:17]) + int'(f[16:13]);
      hour   = 10 * int'(f[12:11]) + int'(f[10:7]);
      minute = 10 * int'(f[6:4])   + int'(f[3:0]);
      return digitsOk && (month >= 1) && (month <= 12) && (day >= 1) && (day <= 31) &&
             (hour <= 23) && (minute <= 59);
   endfunction

   assign frameOk = frameValid(bus.frame_bcd_i);

   // Rejected frames only raise a one-cycle flag; arming logic never sees them.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         reject_q <= 1'b0;
      end else begin
         reject_q <= bus.frame_valid_i && !frameOk;
      end
   end

   assign bus.reject_o = reject_q;
`else
   assign frameOk      = 1'b1;
   assign bus.reject_o = 1'b0;
`endif

   // Prescaler, sync flag and arm/load sequencing; every output is a register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= UNSYNC;
         preCnt_q   <= '0;
         timeout_q  <= '0;
         holdover_q <= '0;
         shadow_q   <= '0;
         loadBcd_q  <= '0;
         inc_q      <= 1'b0;
         load_q     <= 1'b0;
         synced_q   <= 1'b0;
         pending_q  <= 1'b0;
      end else begin
         inc_q    <= incNow;
         load_q   <= loadNow;
         preCnt_q <= (loadNow || terminal) ? '0 : preCnt_q + 1'b1;

         if (loadNow) begin
            loadBcd_q  <= shadow_q;
            synced_q   <= 1'b1;
            holdover_q <= '0;
         end else if (synced_q && incNow && (holdover_q != HoldLast)) begin
            holdover_q <= holdover_d;
            if (holdExpire) begin
               synced_q <= 1'b0;
            end
         end

         // A frame arriving with the marker is latched after the old shadow is consumed.
         if (frameAccept) begin
            shadow_q  <= bus.frame_bcd_i;
            pending_q <= 1'b1;
            timeout_q <= '0;
            state_q   <= ARMED;
         end else if (loadNow) begin
            pending_q <= 1'b0;
            timeout_q <= '0;
            state_q   <= SYNCED;
         end else if (state_q == ARMED) begin
            if (incNow) begin
               if (toutExpire) begin
                  pending_q <= 1'b0;
                  timeout_q <= '0;
                  state_q   <= (synced_q && !holdExpire) ? SYNCED : UNSYNC;
               end else begin
                  timeout_q <= timeout_d;
               end
            end
         end else if ((state_q == SYNCED) && holdExpire) begin
            state_q <= UNSYNC;
         end
      end
   end

   assign bus.inc_o      = inc_q;
   assign bus.load_o     = load_q;
   assign bus.load_bcd_o = loadBcd_q;
   assign bus.synced_o   = synced_q;
   assign bus.pending_o  = pending_q;

endmodule

// File: tb/tb_time_sync_ctrl.sv
// Directed + randomised bench for time_sync_ctrl, checked every cycle against a
// reference model that tracks absolute tick times and whole-second tallies.
module tb_time_sync_ctrl;

   localparam int TickDiv      = 10;
   localparam int ArmedTimeout = 3;
   localparam int Holdover     = 5;

   logic clk;
   logic rst_n;

   time_sync_ctrl_if bus();

   time_sync_ctrl #(
      .TICK_DIV        (TickDiv),
      .ARMED_TIMEOUT_S (ArmedTimeout),
      .HOLDOVER_S      (Holdover)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   int checkCount;
   int errorCount;

   // Model: cycM counts edges since reset release, nextIncM is the edge of the next second.
   longint      cycM;
   longint      nextIncM;
   bit          armedM;
   bit          syncedM;
   bit          incM;
   bit          loadM;
   bit          rejectM;
   logic [31:0] shadowM;
   logic [31:0] loadBcdM;
   int          waitSecM;
   int          holdSecM;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, observed, expected, cycM);
      end
   endtask

   function automatic logic [31:0] packFrame(input int yh, input int yl, input int mh, input int ml,
                                             input int dh, input int dl, input int hh, input int hl,
                                             input int nh, input int nl);
      return {4'(yh), 4'(yl), 1'(mh), 4'(ml), 2'(dh), 4'(dl), 2'(hh), 4'(hl), 3'(nh), 4'(nl)};
   endfunction

   function automatic logic [31:0] randomFrame();
      int year;
      int month;
      int day;
      int hour;
      int minute;
      if ($urandom_range(0, 3) == 0) begin
         return $urandom;
      end
      year   = $urandom_range(0, 99);
      month  = $urandom_range(1, 12);
      day    = $urandom_range(1, 31);
      hour   = $urandom_range(0, 23);
      minute = $urandom_range(0, 59);
      return packFrame(year / 10, year % 10, month / 10, month % 10, day / 10, day % 10,
                       hour / 10, hour % 10, minute / 10, minute % 10);
   endfunction

   function automatic bit frameAcceptable(input logic [31:0] f);
`ifdef FRAME_CHECK_EN
      logic [3:0] yh, yl, ml, dl, hl, nl;
      logic       mh;
      logic [1:0] dh, hh;
      logic [2:0] nh;
      int         month, day, hour, minute;
      {yh, yl, mh, ml, dh, dl, hh, hl, nh, nl} = f;
      if (yh > 9 || yl > 9 || ml > 9 || dl > 9 || hl > 9 || nl > 9) begin
         return 1'b0;
      end
      month  = mh * 10 + ml;
      day    = dh * 10 + dl;
      hour   = hh * 10 + hl;
      minute = nh * 10 + nl;
      return (month >= 1 && month <= 12 && day >= 1 && day <= 31 && hour <= 23 && minute <= 59);
`else
      return (f === f);
`endif
   endfunction

   task automatic modelReset();
      cycM     = 0;
      nextIncM = TickDiv;
      armedM   = 1'b0;
      syncedM  = 1'b0;
      incM     = 1'b0;
      loadM    = 1'b0;
      rejectM  = 1'b0;
      shadowM  = '0;
      loadBcdM = '0;
      waitSecM = 0;
      holdSecM = 0;
   endtask

   task automatic modelStep(input bit fv, input logic [31:0] fb, input bit mm);
      bit ok;
      cycM++;
      loadM = armedM && mm;
      incM  = (cycM == nextIncM) && !loadM;
      if (loadM || cycM == nextIncM) begin
         nextIncM = cycM + TickDiv;
      end
      if (loadM) begin
         loadBcdM = shadowM;
         syncedM  = 1'b1;
         holdSecM = 0;
      end else if (incM && syncedM) begin
         holdSecM++;
         if (holdSecM >= Holdover) syncedM = 1'b0;
      end
      ok      = frameAcceptable(fb);
      rejectM = fv && !ok;
      if (fv && ok) begin
         armedM   = 1'b1;
         shadowM  = fb;
         waitSecM = 0;
      end else if (loadM) begin
         armedM = 1'b0;
      end else if (armedM && incM) begin
         waitSecM++;
         if (waitSecM >= ArmedTimeout) armedM = 1'b0;
      end
   endtask

   task automatic compareAll();
      checkOutput("inc",     32'(bus.inc_o),     32'(incM));
      checkOutput("load",    32'(bus.load_o),    32'(loadM));
      checkOutput("loadBcd", bus.load_bcd_o,     loadBcdM);
      checkOutput("synced",  32'(bus.synced_o),  32'(syncedM));
      checkOutput("pending", 32'(bus.pending_o), 32'(armedM));
      checkOutput("reject",  32'(bus.reject_o),  32'(rejectM));
   endtask

   // One clock cycle: drive at negedge, let the DUT and model take the edge, compare at the next negedge.
   task automatic applyStimulus(input bit fv, input logic [31:0] fb, input bit mm);
      bus.frame_valid_i = fv;
      bus.frame_bcd_i   = fb;
      bus.minute_mark_i = mm;
      @(posedge clk);
      modelStep(fv, fb, mm);
      @(negedge clk);
      bus.frame_valid_i = 1'b0;
      bus.minute_mark_i = 1'b0;
      compareAll();
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 32'h0, 1'b0);
   endtask

   task automatic asyncReset();
      #2;
      rst_n = 1'b0;
      #1;
      modelReset();
      compareAll();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [31:0] frameA;
   logic [31:0] frameB;
   logic [31:0] badMonth;
   logic [31:0] badMinute;
   int          secs;
   int          guard;

   initial begin
      checkCount        = 0;
      errorCount        = 0;
      bus.frame_valid_i = 1'b0;
      bus.frame_bcd_i   = '0;
      bus.minute_mark_i = 1'b0;
      rst_n             = 1'b0;
      modelReset();
      frameA    = packFrame(2, 4, 1, 2, 3, 1, 2, 3, 5, 9);
      frameB    = packFrame(2, 5, 0, 7, 1, 4, 0, 8, 3, 0);
      badMonth  = packFrame(2, 4, 1, 3, 1, 5, 1, 0, 2, 0);
      badMinute = packFrame(2, 4, 0, 6, 1, 5, 1, 0, 2, 10);

      repeat (3) @(negedge clk);
      compareAll();
      rst_n = 1'b1;

      $display("[TB] free-running prescaler after reset");
      idle(9);
      checkOutput("t1_noIncYet", 32'(bus.inc_o), 32'd0);
      idle(1);
      checkOutput("t1_firstInc", 32'(bus.inc_o), 32'd1);
      idle(25);
      checkOutput("t1_stillUnsynced", 32'(bus.synced_o), 32'd0);

      $display("[TB] frame then marker");
      applyStimulus(1'b1, frameA, 1'b0);
      checkOutput("t2_pending", 32'(bus.pending_o), 32'd1);
      idle(3);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("t2_load", 32'(bus.load_o), 32'd1);
      checkOutput("t2_loadBcd", bus.load_bcd_o, frameA);
      checkOutput("t2_synced", 32'(bus.synced_o), 32'd1);
      checkOutput("t2_incWithLoad", 32'(bus.inc_o), 32'd0);
      idle(9);
      checkOutput("t2_noEarlyInc", 32'(bus.inc_o), 32'd0);
      idle(1);
      checkOutput("t2_incAfterLoad", 32'(bus.inc_o), 32'd1);

      $display("[TB] stray marker, then frame with marker in same cycle");
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("t3_strayNoLoad", 32'(bus.load_o), 32'd0);
      applyStimulus(1'b1, frameB, 1'b1);
      checkOutput("t3_sameCycleNoLoad", 32'(bus.load_o), 32'd0);
      checkOutput("t3_sameCyclePending", 32'(bus.pending_o), 32'd1);
      idle(2);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("t3_laterLoad", 32'(bus.load_o), 32'd1);
      checkOutput("t3_laterLoadBcd", bus.load_bcd_o, frameB);

      $display("[TB] implausible frames");
      applyStimulus(1'b1, badMonth, 1'b0);
`ifdef FRAME_CHECK_EN
      checkOutput("t4_month13Reject", 32'(bus.reject_o), 32'd1);
      checkOutput("t4_month13Pending", 32'(bus.pending_o), 32'd0);
`else
      checkOutput("t4_month13Reject", 32'(bus.reject_o), 32'd0);
      checkOutput("t4_month13Pending", 32'(bus.pending_o), 32'd1);
`endif
      idle(1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      idle(2);
      applyStimulus(1'b1, badMinute, 1'b0);
`ifdef FRAME_CHECK_EN
      checkOutput("t4_minuteAReject", 32'(bus.reject_o), 32'd1);
      checkOutput("t4_minuteAPending", 32'(bus.pending_o), 32'd0);
`else
      checkOutput("t4_minuteAReject", 32'(bus.reject_o), 32'd0);
      checkOutput("t4_minuteAPending", 32'(bus.pending_o), 32'd1);
`endif
      idle(1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      idle(2);

      $display("[TB] armed timeout");
      applyStimulus(1'b1, frameA, 1'b0);
      secs  = 0;
      guard = 0;
      while (secs < ArmedTimeout && guard < (ArmedTimeout + 1) * TickDiv) begin
         applyStimulus(1'b0, 32'h0, 1'b0);
         if (incM) secs++;
         guard++;
      end
      checkOutput("t5_secondsSeen", 32'(secs), 32'(ArmedTimeout));
      checkOutput("t5_pendingDrop", 32'(bus.pending_o), 32'd0);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("t5_noLoadAfterTimeout", 32'(bus.load_o), 32'd0);

      $display("[TB] holdover expiry");
      applyStimulus(1'b1, frameB, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("t6_load", 32'(bus.load_o), 32'd1);
      secs  = 0;
      guard = 0;
      while (secs < Holdover && guard < (Holdover + 1) * TickDiv) begin
         applyStimulus(1'b0, 32'h0, 1'b0);
         if (incM) secs++;
         guard++;
      end
      checkOutput("t6_secondsSeen", 32'(secs), 32'(Holdover));
      checkOutput("t6_syncedDrop", 32'(bus.synced_o), 32'd0);

      $display("[TB] marker on prescaler wrap");
      applyStimulus(1'b1, frameA, 1'b0);
      guard = 0;
      while ((cycM + 1) != nextIncM && guard < TickDiv + 2) begin
         idle(1);
         guard++;
      end
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("t6_alignLoad", 32'(bus.load_o), 32'd1);
      checkOutput("t6_alignIncSuppressed", 32'(bus.inc_o), 32'd0);
      idle(9);
      checkOutput("t6_alignNoEarlyInc", 32'(bus.inc_o), 32'd0);
      idle(1);
      checkOutput("t6_alignIncAfter", 32'(bus.inc_o), 32'd1);

      $display("[TB] asynchronous reset mid-run");
      asyncReset();
      idle(10);
      checkOutput("t7_firstIncAfterReset", 32'(bus.inc_o), 32'd1);

      $display("[TB] randomised traffic");
      repeat (2500) begin
         applyStimulus(($urandom_range(0, 19) == 0), randomFrame(), ($urandom_range(0, 14) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
